// File: rtl/ex_mem_buffer_pkg.sv
// Shared types and constants for the EX/MEM elastic buffer.
// Entry layout and occupancy encodings used by the buffer and its FIFO.
package ex_mem_buffer_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              branch;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [DATA_W-1:0] write_data;
    } ex_mem_t;

    localparam int ENTRY_W = $bits(ex_mem_t);

endpackage

// File: rtl/ex_mem_fifo2.sv
// Generic two-entry FIFO over a packed word.
// Registered head output, no same-cycle bypass.
module ex_mem_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         enq,
    input  logic         deq,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, enq} - {1'b0, deq};
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/ex_mem_buffer.sv
// EX/MEM skid buffer: qualifies EX results into a 2-entry FIFO,
// raises ex_stall, and masks MEM controls when nothing is buffered.
module ex_mem_buffer #(
    parameter int DATA_W = ex_mem_buffer_pkg::DATA_W,
    parameter int REG_W  = ex_mem_buffer_pkg::REG_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ex_valid,
    input  logic              alu_ready,
    input  logic              flush_ex,
    input  logic [DATA_W-1:0] alu_result_ex,
    input  logic              branch_alu,
    input  logic [REG_W-1:0]  rd_ex,
    input  logic              reg_write_ex,
    input  logic              mem_read_ex,
    input  logic              mem_write_ex,
    input  logic [DATA_W-1:0] write_data_ex,
    input  logic              data_ready_mem,
    output logic              ex_stall,
    output logic              mem_valid,
    output logic [DATA_W-1:0] alu_result_mem,
    output logic              branch_mem,
    output logic [REG_W-1:0]  rd_mem,
    output logic              reg_write_mem,
    output logic              mem_read_mem,
    output logic              mem_write_mem,
    output logic [DATA_W-1:0] write_data_mem,
    output logic [1:0]        buf_count
);

    import ex_mem_buffer_pkg::*;

    ex_mem_t    in_e;
    ex_mem_t    head;
    logic [1:0] count;
    logic       full;
    logic       enq;
    logic       deq;

    assign in_e = '{
        result:     alu_result_ex,
        branch:     branch_alu,
        rd:         rd_ex,
        reg_write:  reg_write_ex,
        mem_read:   mem_read_ex,
        mem_write:  mem_write_ex,
        write_data: write_data_ex
    };

    // Full is judged on the registered count so MEM ready never reaches ex_stall.
    assign full      = (count == CNT_FULL);
    assign enq       = ex_valid & alu_ready & ~flush_ex & ~full;
    assign mem_valid = (count != CNT_EMPTY);
    assign deq       = mem_valid & data_ready_mem;
    assign ex_stall  = full | (ex_valid & ~alu_ready & ~flush_ex);

    ex_mem_fifo2 #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .enq   (enq),
        .deq   (deq),
        .din   (in_e),
        .dout  (head),
        .count (count)
    );

    assign buf_count      = count;
    assign alu_result_mem = head.result;
    assign branch_mem     = head.branch;
    assign rd_mem         = head.rd;
    assign write_data_mem = head.write_data;
    assign reg_write_mem  = head.reg_write & mem_valid;
    assign mem_read_mem   = head.mem_read & mem_valid;
    assign mem_write_mem  = head.mem_write & mem_valid;

    a_depth: assert property (@(posedge clk)
        DEPTH == 2 && DATA_W == ex_mem_buffer_pkg::DATA_W
        && REG_W == ex_mem_buffer_pkg::REG_W);
    a_cnt: assert property (@(posedge clk) disable iff (!rstn)
        count <= CNT_FULL);
    a_noenq: assert property (@(posedge clk) disable iff (!rstn)
        !(enq && full));
    a_valid: assert property (@(posedge clk) disable iff (!rstn)
        mem_valid == (count != CNT_EMPTY));

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Self-checking bench for ex_mem_buffer: directed vector table,
// reset corner case and random traffic against a queue model.
module tb_ex_mem_buffer;

    import ex_mem_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ex_valid, alu_ready, flush_ex;
    logic [31:0] alu_result_ex, write_data_ex;
    logic        branch_alu;
    logic [4:0]  rd_ex;
    logic        reg_write_ex, mem_read_ex, mem_write_ex;
    logic        data_ready_mem;
    logic        ex_stall, mem_valid;
    logic [31:0] alu_result_mem, write_data_mem;
    logic        branch_mem;
    logic [4:0]  rd_mem;
    logic        reg_write_mem, mem_read_mem, mem_write_mem;
    logic [1:0]  buf_count;

    always #5 clk = ~clk;

    ex_mem_buffer dut (
        .clk            (clk),
        .rstn           (rstn),
        .ex_valid       (ex_valid),
        .alu_ready      (alu_ready),
        .flush_ex       (flush_ex),
        .alu_result_ex  (alu_result_ex),
        .branch_alu     (branch_alu),
        .rd_ex          (rd_ex),
        .reg_write_ex   (reg_write_ex),
        .mem_read_ex    (mem_read_ex),
        .mem_write_ex   (mem_write_ex),
        .write_data_ex  (write_data_ex),
        .data_ready_mem (data_ready_mem),
        .ex_stall       (ex_stall),
        .mem_valid      (mem_valid),
        .alu_result_mem (alu_result_mem),
        .branch_mem     (branch_mem),
        .rd_mem         (rd_mem),
        .reg_write_mem  (reg_write_mem),
        .mem_read_mem   (mem_read_mem),
        .mem_write_mem  (mem_write_mem),
        .write_data_mem (write_data_mem),
        .buf_count      (buf_count)
    );

    typedef struct {
        logic        ev, ar, fl;
        logic [31:0] res;
        logic        drm;
        logic        e_valid;
        logic [31:0] e_res;
        logic [1:0]  e_cnt;
        logic        e_stall;
    } vec_t;

    vec_t    tbl[$];
    ex_mem_t mq[$];
    int      n_chk = 0;
    int      n_fail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(logic ev, logic ar, logic fl, logic [31:0] res,
                       logic drm, logic ev_o, logic [31:0] r_o,
                       logic [1:0] c_o, logic st_o);
        vec_t v;
        v = '{ev, ar, fl, res, drm, ev_o, r_o, c_o, st_o};
        tbl.push_back(v);
    endtask

    task automatic drive(logic ev, logic ar, logic fl, logic [31:0] res,
                         logic drm);
        ex_valid       = ev;
        alu_ready      = ar;
        flush_ex       = fl;
        alu_result_ex  = res;
        rd_ex          = res[4:0];
        reg_write_ex   = 1'b1;
        mem_read_ex    = res[0];
        mem_write_ex   = res[1];
        write_data_ex  = ~res;
        branch_alu     = (res == 32'd0);
        data_ready_mem = drm;
    endtask

    task automatic drive_rand();
        ex_valid       = ($urandom_range(0, 9) < 8);
        alu_ready      = ($urandom_range(0, 3) != 0);
        flush_ex       = ($urandom_range(0, 7) == 0);
        alu_result_ex  = $urandom;
        write_data_ex  = $urandom;
        rd_ex          = 5'($urandom);
        branch_alu     = 1'($urandom);
        reg_write_ex   = 1'($urandom);
        mem_read_ex    = 1'($urandom);
        mem_write_ex   = 1'($urandom);
        data_ready_mem = 1'($urandom);
    endtask

    // Compare DUT outputs to the queue model; call mid-cycle.
    task automatic sample(string tag);
        logic v;
        logic st;
        v  = (mq.size() != 0);
        st = (mq.size() == 2) || (ex_valid && !alu_ready && !flush_ex);
        chk({tag, " mem_valid"}, 64'(mem_valid), 64'(v));
        chk({tag, " buf_count"}, 64'(buf_count), 64'(mq.size()));
        chk({tag, " ex_stall"}, 64'(ex_stall), 64'(st));
        if (v) begin
            chk({tag, " result"}, 64'(alu_result_mem), 64'(mq[0].result));
            chk({tag, " branch"}, 64'(branch_mem), 64'(mq[0].branch));
            chk({tag, " rd"}, 64'(rd_mem), 64'(mq[0].rd));
            chk({tag, " ctrl"},
                64'({reg_write_mem, mem_read_mem, mem_write_mem}),
                64'({mq[0].reg_write, mq[0].mem_read, mq[0].mem_write}));
            chk({tag, " wdata"}, 64'(write_data_mem), 64'(mq[0].write_data));
        end else begin
            chk({tag, " ctrl_masked"},
                64'({reg_write_mem, mem_read_mem, mem_write_mem}), 64'(0));
        end
    endtask

    // Model update at the clock edge, then settle to posedge+1.
    task automatic advance();
        logic    enq, deq;
        ex_mem_t e;
        enq = ex_valid && alu_ready && !flush_ex && (mq.size() < 2);
        deq = (mq.size() != 0) && data_ready_mem;
        e = '{alu_result_ex, branch_alu, rd_ex, reg_write_ex,
              mem_read_ex, mem_write_ex, write_data_ex};
        @(posedge clk);
        if (deq) void'(mq.pop_front());
        if (enq) mq.push_back(e);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        drive(0, 0, 0, 32'd0, 0);
        #3;
        chk("rst mem_valid", 64'(mem_valid), 64'(0));
        chk("rst buf_count", 64'(buf_count), 64'(0));
        chk("rst ex_stall", 64'(ex_stall), 64'(0));
        chk("rst data", 64'({alu_result_mem, write_data_mem}), 64'(0));
        chk("rst rd_br", 64'({rd_mem, branch_mem}), 64'(0));
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;

        // streaming
        add(1, 1, 0, 32'd1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 32'd2, 1, 1, 1, 1, 0);
        add(1, 1, 0, 32'd3, 1, 1, 2, 1, 0);
        add(1, 1, 0, 32'd4, 1, 1, 3, 1, 0);
        add(0, 0, 0, 32'd0, 1, 1, 4, 1, 0);
        add(0, 0, 0, 32'd0, 0, 0, 0, 0, 0);
        // backpressure
        add(1, 1, 0, 32'hA, 0, 0, 0, 0, 0);
        add(1, 1, 0, 32'hB, 0, 1, 32'hA, 1, 0);
        add(1, 1, 0, 32'hC, 0, 1, 32'hA, 2, 1);
        add(1, 1, 0, 32'hC, 1, 1, 32'hA, 2, 1);
        add(1, 1, 0, 32'hC, 0, 1, 32'hB, 1, 0);
        add(0, 0, 0, 32'd0, 1, 1, 32'hB, 2, 1);
        add(0, 0, 0, 32'd0, 1, 1, 32'hC, 1, 0);
        add(0, 0, 0, 32'd0, 0, 0, 0, 0, 0);
        // FPU wait
        for (int i = 0; i < 5; i++)
            add(1, 0, 0, 32'h3F800000, 0, 0, 0, 0, 1);
        add(1, 1, 0, 32'h3F800000, 0, 0, 0, 0, 0);
        add(0, 0, 0, 32'd0, 0, 1, 32'h3F800000, 1, 0);
        add(0, 0, 0, 32'd0, 1, 1, 32'h3F800000, 1, 0);
        add(0, 0, 0, 32'd0, 0, 0, 0, 0, 0);
        // flush
        add(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
        add(1, 1, 1, 32'h20, 0, 1, 32'h10, 1, 0);
        add(0, 0, 0, 32'd0, 1, 1, 32'h10, 1, 0);
        add(0, 0, 0, 32'd0, 0, 0, 0, 0, 0);
        // full with simultaneous dequeue, then dequeue while empty
        add(1, 1, 0, 32'h1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 32'h2, 0, 1, 32'h1, 1, 0);
        add(1, 1, 0, 32'h3, 1, 1, 32'h1, 2, 1);
        add(1, 1, 0, 32'h3, 0, 1, 32'h2, 1, 0);
        add(0, 0, 0, 32'd0, 1, 1, 32'h2, 2, 1);
        add(0, 0, 0, 32'd0, 1, 1, 32'h3, 1, 0);
        add(0, 0, 0, 32'd0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 32'd0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].ev, tbl[i].ar, tbl[i].fl, tbl[i].res, tbl[i].drm);
            #4;
            sample(tag);
            chk({tag, " t_valid"}, 64'(mem_valid), 64'(tbl[i].e_valid));
            chk({tag, " t_count"}, 64'(buf_count), 64'(tbl[i].e_cnt));
            chk({tag, " t_stall"}, 64'(ex_stall), 64'(tbl[i].e_stall));
            if (tbl[i].e_valid)
                chk({tag, " t_result"}, 64'(alu_result_mem),
                    64'(tbl[i].e_res));
            advance();
        end

        // async reset with two entries buffered
        drive(1, 1, 0, 32'h61, 0);
        #4 sample("pre_rst0");
        advance();
        drive(1, 1, 0, 32'h62, 0);
        #4 sample("pre_rst1");
        advance();
        drive(0, 0, 0, 32'd0, 0);
        #2 rstn = 1'b0;
        #1;
        chk("arst mem_valid", 64'(mem_valid), 64'(0));
        chk("arst buf_count", 64'(buf_count), 64'(0));
        chk("arst ex_stall", 64'(ex_stall), 64'(0));
        mq.delete();
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 1, 0, 32'h55, 0);
        rd_ex         = 5'd7;
        reg_write_ex  = 1'b1;
        mem_read_ex   = 1'b0;
        mem_write_ex  = 1'b1;
        write_data_ex = 32'hDEAD;
        #4 sample("post_rst push");
        advance();
        drive(0, 0, 0, 32'd0, 1);
        #4 sample("post_rst head");
        chk("post_rst result", 64'(alu_result_mem), 64'h55);
        chk("post_rst ctrl",
            64'({reg_write_mem, mem_read_mem, mem_write_mem}), 64'b101);
        chk("post_rst rd", 64'(rd_mem), 64'd7);
        advance();
        drive(0, 0, 0, 32'd0, 0);
        #4 sample("post_rst drained");
        advance();

        // random traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            drive_rand();
            #4 sample($sformatf("rnd%0d", c));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_buffer.md
Name: ex_mem_buffer

Overview:
- Two-entry elastic buffer (skid queue) between the execute stage (integer ALU plus multi-cycle FPU) and the memory stage.
- Captures each completed EX result together with its writeback/memory control bits.
- Presents results to MEM in program order and holds them until MEM signals data_ready_mem.
- Generates the EX stall so a slow memory access never drops or duplicates an FPU/ALU result.

Parameters:
- DATA_W, 32, width of ALU result and store data
- REG_W, 5, destination register index width
- DEPTH, 2, entries (fixed at 2; other values unsupported, checked by assertion)

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- ex_valid  input  1  EX holds a live instruction
- alu_ready  input  1  EX result valid this cycle (high for integer ops, FPU done for float ops)
- flush_ex  input  1  kill the instruction currently in EX
- alu_result_ex  input  DATA_W  EX result
- branch_alu  input  1  zero flag from EX
- rd_ex  input  REG_W  destination register
- reg_write_ex  input  1  writeback enable
- mem_read_ex  input  1  load
- mem_write_ex  input  1  store
- write_data_ex  input  DATA_W  store data
- data_ready_mem  input  1  MEM consumes head entry this cycle
- ex_stall  output  1  freeze EX and earlier stages
- mem_valid  output  1  head entry valid
- alu_result_mem  output  DATA_W  head result
- branch_mem  output  1  head zero flag
- rd_mem  output  REG_W  head destination
- reg_write_mem, mem_read_mem, mem_write_mem  output  1 each  head controls (all forced 0 when mem_valid=0)
- write_data_mem  output  DATA_W  head store data
- buf_count  output  2  occupancy 0..2

Behaviour:
- Storage: 2 entries, each {result, branch, rd, reg_write, mem_read, mem_write, write_data}. 1-bit rd_ptr, 1-bit wr_ptr, 2-bit count.
- Reset (rstn low, asynchronous): count=0, pointers=0, all entry fields=0. Outputs: mem_valid=0, buf_count=0, all data/control outputs=0, ex_stall=0.
- Enqueue when enq = ex_valid & alu_ready & ~flush_ex & (count!=2). Writes entry[wr_ptr]; wr_ptr toggles.
- Dequeue when deq = mem_valid & data_ready_mem. rd_ptr toggles.
- count_next = count + enq - deq. Simultaneous enq and deq leaves count unchanged.
- Full gating uses the registered count only. When count==2, enq=0 even if deq=1 in the same cycle. There is no combinational path data_ready_mem -> ex_stall.
- ex_stall = (count==2) | (ex_valid & ~alu_ready & ~flush_ex).
  - Second term holds EX while the FPU is busy.
  - Flushed instructions never stall.
- Latency:
  - An entry enqueued in cycle N is visible on outputs (mem_valid=1) in cycle N+1.
  - No same-cycle bypass, including when the buffer is empty.
- Outputs are driven from entry[rd_ptr]:
  - mem_valid = (count!=0).
  - Control outputs are ANDed with mem_valid.
  - Data outputs show the stale entry when empty; checkers must not compare them then.
- Order: strict FIFO; pointer wrap from 1 to 0 is natural 1-bit overflow.
- Flush semantics:
  - flush_ex affects only the EX instruction.
  - Buffered entries are older and are always retained and delivered.
- data_ready_mem while empty: ignored, no underflow, count stays 0.
- Reset mid-operation: all entries discarded immediately (asynchronous). First enqueue after rstn deasserts lands in entry 0.
- Assertions:
  - count never exceeds 2.
  - No enq when count==2.
  - mem_valid==(count!=0).

Decomposition:
- Shared package holds:
  - EX/MEM entry struct (result, branch, rd, reg_write, mem_read, mem_write, write_data).
  - DATA_W / REG_W constants.
  - Localparams for count encodings (EMPTY=0, ONE=1, FULL=2).
- One natural sub-module: ex_mem_fifo2, a generic 2-entry FIFO over the packed entry. The top handles the enqueue qualification, ex_stall and output masking.

Test Plan:
- Streaming: ex_valid=1, alu_ready=1 for 4 cycles with results 1,2,3,4; data_ready_mem=1 -> alu_result_mem shows 1,2,3,4 on consecutive cycles starting 1 cycle later; buf_count stays 1; ex_stall=0.
- Backpressure: push 0xA, 0xB with data_ready_mem=0 -> buf_count=2, ex_stall=1, a third push of 0xC is not taken. Raise data_ready_mem for one cycle -> head becomes 0xB, ex_stall drops next cycle, 0xC enqueues after that.
- FPU wait: ex_valid=1, alu_ready=0 for 5 cycles then 1 with result 0x3F800000 -> ex_stall=1 for those 5 cycles; entry appears with mem_valid=1 the cycle after alu_ready rises; exactly one enqueue.
- Flush: count=1 holding 0x10, flush_ex=1 with ex_valid=1, alu_ready=1, result 0x20 -> 0x20 never appears; 0x10 still delivered; ex_stall=0.
- Full with simultaneous deq: count=2 holding 0x1, 0x2, data_ready_mem=1 and a new push 0x3 in the same cycle -> 0x3 rejected; count=1 with head 0x2; 0x3 accepted the next cycle.
- Async reset mid-stream: drop rstn with count=2, between clock edges -> mem_valid=0, buf_count=0 immediately. After release, push 0x55 -> delivered first, with reg_write/mem_* matching its inputs.
